// File: rtl/tdm_demux4.sv
// Receive side of a 4-slot TDM link: steers samples into slot shadows and
// publishes whole frames atomically. Optional parity checking via TDM_PARITY_EN.
module tdm_demux4 #(
  parameter int unsigned WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  input  logic             sync,
`ifdef TDM_PARITY_EN
  input  logic             din_par,
  output logic             par_err,
`endif
  output logic [WIDTH-1:0] y0,
  output logic [WIDTH-1:0] y1,
  output logic [WIDTH-1:0] y2,
  output logic [WIDTH-1:0] y3,
  output logic             frame_valid,
  output logic             locked,
  output logic             sync_err
);

  localparam int unsigned SLOT_W = 2;

  typedef enum logic {
    HUNT   = 1'b0,
    LOCKED = 1'b1
  } state_e;

  state_e             state_q, state_d;
  logic [SLOT_W-1:0]  slot_q, slot_d;
  logic [WIDTH-1:0]   sh0_q, sh0_d, sh1_q, sh1_d, sh2_q, sh2_d;
  logic [WIDTH-1:0]   y0_q, y0_d, y1_q, y1_d, y2_q, y2_d, y3_q, y3_d;
  logic               fv_q, fv_d;
  logic               serr_q, serr_d;

`ifdef TDM_PARITY_EN
  logic par_bad_c;
  logic ferr_q, ferr_d;
  logic perr_q, perr_d;

  // Even parity: din_par must equal the XOR of all din bits.
  assign par_bad_c = din_par ^ (^din);
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= HUNT;
      slot_q  <= '0;
      sh0_q   <= '0;
      sh1_q   <= '0;
      sh2_q   <= '0;
      y0_q    <= '0;
      y1_q    <= '0;
      y2_q    <= '0;
      y3_q    <= '0;
      fv_q    <= 1'b0;
      serr_q  <= 1'b0;
`ifdef TDM_PARITY_EN
      ferr_q  <= 1'b0;
      perr_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      slot_q  <= slot_d;
      sh0_q   <= sh0_d;
      sh1_q   <= sh1_d;
      sh2_q   <= sh2_d;
      y0_q    <= y0_d;
      y1_q    <= y1_d;
      y2_q    <= y2_d;
      y3_q    <= y3_d;
      fv_q    <= fv_d;
      serr_q  <= serr_d;
`ifdef TDM_PARITY_EN
      ferr_q  <= ferr_d;
      perr_q  <= perr_d;
`endif
    end
  end

  // Next-state: idle cycles hold everything and drop the pulses.
  always_comb begin
    state_d = state_q;
    slot_d  = slot_q;
    sh0_d   = sh0_q;
    sh1_d   = sh1_q;
    sh2_d   = sh2_q;
    y0_d    = y0_q;
    y1_d    = y1_q;
    y2_d    = y2_q;
    y3_d    = y3_q;
    fv_d    = 1'b0;
    serr_d  = 1'b0;
`ifdef TDM_PARITY_EN
    ferr_d  = ferr_q;
    perr_d  = 1'b0;
`endif
    if (din_valid) begin
      unique case (state_q)
        HUNT: begin
          if (sync) begin
            sh0_d   = din;
            slot_d  = SLOT_W'(1);
            state_d = LOCKED;
`ifdef TDM_PARITY_EN
            ferr_d  = 1'b0;
`endif
          end
        end
        LOCKED: begin
          if (sync && (slot_q != SLOT_W'(0))) begin
            // Misplaced sync: drop the partial frame and realign on this sample.
            serr_d = 1'b1;
            sh0_d  = din;
            slot_d = SLOT_W'(1);
`ifdef TDM_PARITY_EN
            ferr_d = par_bad_c;
`endif
          end else begin
            unique case (slot_q)
              SLOT_W'(0): sh0_d = din;
              SLOT_W'(1): sh1_d = din;
              SLOT_W'(2): sh2_d = din;
              default: begin
                y0_d = sh0_q;
                y1_d = sh1_q;
                y2_d = sh2_q;
                y3_d = din;
                fv_d = 1'b1;
              end
            endcase
            slot_d = slot_q + SLOT_W'(1);
`ifdef TDM_PARITY_EN
            if (slot_q == SLOT_W'(3)) begin
              perr_d = ferr_q | par_bad_c;
              ferr_d = 1'b0;
            end else begin
              ferr_d = ferr_q | par_bad_c;
            end
`endif
          end
        end
        default: state_d = HUNT;
      endcase
    end
  end

  assign y0          = y0_q;
  assign y1          = y1_q;
  assign y2          = y2_q;
  assign y3          = y3_q;
  assign frame_valid = fv_q;
  assign sync_err    = serr_q;
  assign locked      = (state_q == LOCKED);
`ifdef TDM_PARITY_EN
  assign par_err     = perr_q;
`endif

endmodule

// File: tb/tb_tdm_demux4.sv
// Directed bench for tdm_demux4 (WIDTH=4); parity scenario runs when TDM_PARITY_EN is defined.
module tb_tdm_demux4;

  logic       clk;
  logic       rst_n;
  logic [3:0] din;
  logic       din_valid;
  logic       sync;
  logic [3:0] y0, y1, y2, y3;
  logic       frame_valid;
  logic       locked;
  logic       sync_err;
`ifdef TDM_PARITY_EN
  logic       din_par;
  logic       par_err;
`endif

  int errors;
  int checks;

  tdm_demux4 #(.WIDTH(4)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .din         (din),
    .din_valid   (din_valid),
    .sync        (sync),
`ifdef TDM_PARITY_EN
    .din_par     (din_par),
    .par_err     (par_err),
`endif
    .y0          (y0),
    .y1          (y1),
    .y2          (y2),
    .y3          (y3),
    .frame_valid (frame_valid),
    .locked      (locked),
    .sync_err    (sync_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One clock with the given inputs; outputs are stable for checking on return.
  task automatic step(input logic v, input logic s, input logic [3:0] d, input logic bad);
    din_valid = v;
    sync      = s;
    din       = d;
`ifdef TDM_PARITY_EN
    din_par   = (^d) ^ bad;
`else
    if (bad) din = d;
`endif
    @(posedge clk);
    #1;
    din_valid = 1'b0;
    sync      = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    step(1'b1, 1'b1, 4'h5, 1'b0);
    step(1'b0, 1'b0, 4'h0, 1'b0);
    rst_n = 1'b1;
    checks++;
    if ({y0, y1, y2, y3} !== 16'h0000) begin
      errors++; $display("FAIL reset_y: got %h expected 0000", {y0, y1, y2, y3});
    end
    checks++;
    if ({frame_valid, locked, sync_err} !== 3'b000) begin
      errors++; $display("FAIL reset_flags: got %b expected 000", {frame_valid, locked, sync_err});
    end
  endtask

  task automatic test_basic();
    step(1'b1, 1'b1, 4'hA, 1'b0);
    checks++;
    if ({locked, frame_valid} !== 2'b10) begin
      errors++; $display("FAIL basic_lock: got %b expected 10", {locked, frame_valid});
    end
    step(1'b1, 1'b0, 4'hB, 1'b0);
    step(1'b1, 1'b0, 4'hC, 1'b0);
    checks++;
    if (frame_valid !== 1'b0) begin
      errors++; $display("FAIL basic_early_fv: got %b expected 0", frame_valid);
    end
    step(1'b1, 1'b0, 4'hD, 1'b0);
    checks++;
    if ({y0, y1, y2, y3, frame_valid} !== {16'hABCD, 1'b1}) begin
      errors++; $display("FAIL basic_frame: got %h/%b expected abcd/1", {y0, y1, y2, y3}, frame_valid);
    end
    step(1'b0, 1'b0, 4'h0, 1'b0);
    checks++;
    if ({y0, y1, y2, y3, frame_valid} !== {16'hABCD, 1'b0}) begin
      errors++; $display("FAIL basic_hold: got %h/%b expected abcd/0", {y0, y1, y2, y3}, frame_valid);
    end
  endtask

  task automatic test_hunt();
    rst_n = 1'b0;
    step(1'b0, 1'b0, 4'h0, 1'b0);
    rst_n = 1'b1;
    step(1'b1, 1'b0, 4'h1, 1'b0);
    step(1'b1, 1'b0, 4'h2, 1'b0);
    checks++;
    if (locked !== 1'b0) begin
      errors++; $display("FAIL hunt_discard: locked got %b expected 0", locked);
    end
    step(1'b1, 1'b1, 4'h3, 1'b0);
    checks++;
    if ({locked, sync_err} !== 2'b10) begin
      errors++; $display("FAIL hunt_lock: got %b expected 10", {locked, sync_err});
    end
    step(1'b1, 1'b0, 4'h4, 1'b0);
    step(1'b1, 1'b0, 4'h5, 1'b0);
    step(1'b1, 1'b0, 4'h6, 1'b0);
    checks++;
    if ({y0, y1, y2, y3, frame_valid, sync_err} !== {16'h3456, 2'b10}) begin
      errors++; $display("FAIL hunt_frame: got %h/%b%b expected 3456/10", {y0, y1, y2, y3}, frame_valid, sync_err);
    end
  endtask

  task automatic test_gaps();
    logic [3:0] vals [4];
    vals = '{4'h1, 4'h2, 4'h3, 4'h4};
    for (int i = 0; i < 4; i++) begin
      step(1'b1, (i == 0), vals[i], 1'b0);
      if (i == 0) begin
        checks++;
        if (sync_err !== 1'b0) begin
          errors++; $display("FAIL gaps_sync_slot0: sync_err got %b expected 0", sync_err);
        end
      end
      if (i < 3) begin
        step(1'b0, 1'b0, 4'hF, 1'b0);
        checks++;
        if ({y0, y1, y2, y3, frame_valid} !== {16'h3456, 1'b0}) begin
          errors++; $display("FAIL gaps_hold_%0d: got %h/%b expected 3456/0", i, {y0, y1, y2, y3}, frame_valid);
        end
      end
    end
    checks++;
    if ({y0, y1, y2, y3, frame_valid} !== {16'h1234, 1'b1}) begin
      errors++; $display("FAIL gaps_frame: got %h/%b expected 1234/1", {y0, y1, y2, y3}, frame_valid);
    end
    step(1'b0, 1'b0, 4'h0, 1'b0);
    checks++;
    if (frame_valid !== 1'b0) begin
      errors++; $display("FAIL gaps_pulse: frame_valid got %b expected 0", frame_valid);
    end
  endtask

  task automatic test_sync_err();
    step(1'b1, 1'b0, 4'h7, 1'b0);
    step(1'b1, 1'b0, 4'h8, 1'b0);
    step(1'b1, 1'b1, 4'h9, 1'b0);
    checks++;
    if ({sync_err, frame_valid, locked, y0, y1, y2, y3} !== {3'b101, 16'h1234}) begin
      errors++; $display("FAIL serr_pulse: got %b%b%b/%h expected 101/1234", sync_err, frame_valid, locked, {y0, y1, y2, y3});
    end
    step(1'b1, 1'b0, 4'hA, 1'b0);
    checks++;
    if (sync_err !== 1'b0) begin
      errors++; $display("FAIL serr_one_cycle: got %b expected 0", sync_err);
    end
    step(1'b1, 1'b0, 4'hB, 1'b0);
    checks++;
    if ({y0, y1, y2, y3, frame_valid} !== {16'h1234, 1'b0}) begin
      errors++; $display("FAIL serr_hold: got %h/%b expected 1234/0", {y0, y1, y2, y3}, frame_valid);
    end
    step(1'b1, 1'b0, 4'hC, 1'b0);
    checks++;
    if ({y0, y1, y2, y3, frame_valid} !== {16'h9ABC, 1'b1}) begin
      errors++; $display("FAIL serr_realign: got %h/%b expected 9abc/1", {y0, y1, y2, y3}, frame_valid);
    end
  endtask

  task automatic test_reset_mid();
    step(1'b1, 1'b1, 4'h5, 1'b0);
    step(1'b1, 1'b0, 4'h6, 1'b0);
    rst_n = 1'b0;
    step(1'b1, 1'b0, 4'h7, 1'b0);
    rst_n = 1'b1;
    checks++;
    if ({y0, y1, y2, y3, frame_valid, locked, sync_err} !== 19'h0) begin
      errors++; $display("FAIL midrst_clear: got %h/%b%b%b expected 0000/000", {y0, y1, y2, y3}, frame_valid, locked, sync_err);
    end
    step(1'b1, 1'b0, 4'h8, 1'b0);
    step(1'b1, 1'b0, 4'h9, 1'b0);
    step(1'b1, 1'b0, 4'hA, 1'b0);
    checks++;
    if ({y0, y1, y2, y3, frame_valid, locked} !== 18'h0) begin
      errors++; $display("FAIL midrst_ignore: got %h/%b%b expected 0000/00", {y0, y1, y2, y3}, frame_valid, locked);
    end
    step(1'b1, 1'b1, 4'hE, 1'b0);
    step(1'b1, 1'b0, 4'hF, 1'b0);
    step(1'b1, 1'b0, 4'h1, 1'b0);
    step(1'b1, 1'b0, 4'h2, 1'b0);
    checks++;
    if ({y0, y1, y2, y3, frame_valid} !== {16'hEF12, 1'b1}) begin
      errors++; $display("FAIL midrst_relock: got %h/%b expected ef12/1", {y0, y1, y2, y3}, frame_valid);
    end
  endtask

`ifdef TDM_PARITY_EN
  task automatic test_parity();
    step(1'b1, 1'b1, 4'h1, 1'b0);
    step(1'b1, 1'b0, 4'h2, 1'b0);
    step(1'b1, 1'b0, 4'h3, 1'b1);
    checks++;
    if (par_err !== 1'b0) begin
      errors++; $display("FAIL par_early: got %b expected 0", par_err);
    end
    step(1'b1, 1'b0, 4'h4, 1'b0);
    checks++;
    if ({par_err, frame_valid, y0, y1, y2, y3} !== {2'b11, 16'h1234}) begin
      errors++; $display("FAIL par_flag: got %b%b/%h expected 11/1234", par_err, frame_valid, {y0, y1, y2, y3});
    end
    step(1'b1, 1'b1, 4'h5, 1'b0);
    step(1'b1, 1'b0, 4'h6, 1'b0);
    step(1'b1, 1'b0, 4'h7, 1'b0);
    step(1'b1, 1'b0, 4'h8, 1'b0);
    checks++;
    if ({par_err, frame_valid, y0, y1, y2, y3} !== {2'b01, 16'h5678}) begin
      errors++; $display("FAIL par_clean: got %b%b/%h expected 01/5678", par_err, frame_valid, {y0, y1, y2, y3});
    end
  endtask
`endif

  initial begin
    errors    = 0;
    checks    = 0;
    rst_n     = 1'b1;
    din       = '0;
    din_valid = 1'b0;
    sync      = 1'b0;
`ifdef TDM_PARITY_EN
    din_par   = 1'b0;
`endif
    test_reset();
    test_basic();
    test_hunt();
    test_gaps();
    test_sync_err();
    test_reset_mid();
`ifdef TDM_PARITY_EN
    test_parity();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
